// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared constants and helpers for the pipelined adder/subtractor.
//   - ADD / SUB : encodings of the runtime operation select.
//   - sat_max() : largest signed value of a given width (2^(w-1)-1), 64-bit.
//   - sat_min() : smallest signed value of a given width (-2^(w-1)), 64-bit.
//   Callers truncate the 64-bit helper results to their own datapath width.
//   The per-stage record type depends on the top-level width parameter, so
//   it is declared next to the pipeline in pipelined_addsub.
// -----------------------------------------------------------------------------
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  localparam int HELPER_WIDTH = 64;

  function automatic logic [HELPER_WIDTH-1:0] sat_max(input int width);
    return (HELPER_WIDTH'(1) << (width - 1)) - HELPER_WIDTH'(1);
  endfunction

  function automatic logic [HELPER_WIDTH-1:0] sat_min(input int width);
    return HELPER_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/cla_segment.sv
// -----------------------------------------------------------------------------
// cla_segment
//   Combinational SEG-bit carry-lookahead adder built from generate/propagate
//   terms. Each carry is formed directly from g/p/cin rather than rippled.
// Ports
//   a, b   in  SEG  operand segments
//   cin    in  1    carry into bit 0
//   s      out SEG  segment sum
//   cout   out 1    carry out of the MSB
//   c_msb  out 1    carry into the MSB (cout ^ c_msb = signed overflow)
// -----------------------------------------------------------------------------
module cla_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;
  logic           prop;

  // NOTE: every variable written here gets a value before any branch or loop
  // can skip it; otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    prop = 1'b1;
    // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin, built as a flat
    // sum of products walking down from bit i-1.
    for (int i = 1; i <= SEG; i++) begin
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        c[i] = c[i] | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i] = c[i] | (prop & cin);
    end
    s     = p ^ c[SEG-1:0];
    cout  = c[SEG];
    c_msb = c[SEG-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Pipelined signed two's-complement adder/subtractor with valid/ready.
//   The carry chain is cut into STAGES segments of SEG = DATA_WIDTH/STAGES
//   bits; stage k adds segment k using the carry registered by stage k-1.
//   Operands travel with their beat, lower result segments accumulate as the
//   beat moves up. The last stage forms the MSB segment and the overflow flag.
//   Latency STAGES cycles, throughput one beat per cycle. A stalled output
//   freezes the whole pipeline (single global enable), bubbles included.
// Configuration
//   ADDSUB_SATURATE_EN : when defined, an overflowing result is clamped to the
//                        signed max/min in the last stage; otherwise it wraps.
// Ports
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous active-low reset
//   in_valid   in   1           operand beat valid
//   in_ready   out  1           beat accepted this cycle when in_valid
//   a, b       in   DATA_WIDTH  signed operands
//   sub        in   1           0: a+b, 1: a-b
//   out_valid  out  1           result beat valid
//   out_ready  in   1           downstream accepts result
//   result     out  DATA_WIDTH  signed sum/difference
//   overflow   out  1           signed overflow for this beat
// -----------------------------------------------------------------------------
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  localparam int SEG = DATA_WIDTH / STAGES;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));
`endif

  // One pipeline register per stage. b_rem already holds B' (inverted for
  // subtract) so later stages never need the operation select again.
  typedef struct packed {
    logic                  valid;
    logic                  sub;
    logic [DATA_WIDTH-1:0] a_rem;
    logic [DATA_WIDTH-1:0] b_rem;
    logic [DATA_WIDTH-1:0] res_lo;
    logic                  carry;
  } stage_t;

  stage_t                stage_q [STAGES];
  stage_t                stage_d [STAGES];
  logic                  overflow_q;
  logic                  overflow_d;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  stall;

  logic [SEG-1:0] seg_a    [STAGES];
  logic [SEG-1:0] seg_b    [STAGES];
  logic [SEG-1:0] seg_s    [STAGES];
  logic           seg_cin  [STAGES];
  logic           seg_cout [STAGES];
  logic           seg_cmsb [STAGES];

  // Handshake: the only hold condition is a result nobody is taking.
  assign stall     = stage_q[STAGES-1].valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = stage_q[STAGES-1].valid;
  assign result    = stage_q[STAGES-1].res_lo;
  assign overflow  = overflow_q;

  // Segment operands: stage 0 sees the live inputs, stage k>0 sees the
  // skewed operand copy and carry held in stage k-1's register.
  always_comb begin
    b_in       = (sub == ADD) ? b : ~b;
    seg_a[0]   = a[SEG-1:0];
    seg_b[0]   = b_in[SEG-1:0];
    seg_cin[0] = (sub == SUB);
    for (int k = 1; k < STAGES; k++) begin
      seg_a[k]   = stage_q[k-1].a_rem[k*SEG +: SEG];
      seg_b[k]   = stage_q[k-1].b_rem[k*SEG +: SEG];
      seg_cin[k] = stage_q[k-1].carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_segment #(.SEG(SEG)) u_seg (
      .a     (seg_a[k]),
      .b     (seg_b[k]),
      .cin   (seg_cin[k]),
      .s     (seg_s[k]),
      .cout  (seg_cout[k]),
      .c_msb (seg_cmsb[k])
    );
  end

  always_comb begin
    stage_d[0].valid           = in_valid;
    stage_d[0].sub             = sub;
    stage_d[0].a_rem           = a;
    stage_d[0].b_rem           = b_in;
    stage_d[0].res_lo          = '0;
    stage_d[0].res_lo[SEG-1:0] = seg_s[0];
    stage_d[0].carry           = seg_cout[0];
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k]                        = stage_q[k-1];
      stage_d[k].res_lo[k*SEG +: SEG]   = seg_s[k];
      stage_d[k].carry                  = seg_cout[k];
    end
    // Carry into the MSB differing from carry out is signed overflow of
    // a + B' + c0, identical to the operand/result sign rule.
    overflow_d = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
`ifdef ADDSUB_SATURATE_EN
    // Positive overflow is only possible with a >= 0, negative with a < 0.
    if (overflow_d) begin
      stage_d[STAGES-1].res_lo = stage_d[STAGES-1].a_rem[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every stage
  // samples its predecessor's pre-edge value; blocking here would let a beat
  // fall through several stages in one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, not just valids, because result
      // and overflow must read 0 straight after reset.
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
      overflow_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//   Scoreboard bench for pipelined_addsub. The driver pushes the expected
//   result of every accepted beat into a queue; an independent monitor pops
//   and compares whenever a result is handed off. Expected values come from
//   exact integer arithmetic with a range check for overflow.
//   Define ADDSUB_SATURATE_EN for both bench and RTL to check the clamp build.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

  parameter int DATA_WIDTH = 16;
  parameter int STAGES     = 4;
  localparam int W = DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   or_mode = 0;   // 0: out_ready=1, 1: toggle 1010..., 2: random
  logic or_tog = 1'b0;

  always #5 clk = ~clk;

  pipelined_addsub #(.DATA_WIDTH(DATA_WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed arithmetic, overflow = result outside range.
  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    longint      sa, sb, ex, hi, lo;
    logic [63:0] raw;
    exp_t        e;
    sa    = longint'($signed(va));
    sb    = longint'($signed(vb));
    ex    = vs ? (sa - sb) : (sa + sb);
    hi    = (longint'(1) <<< (W - 1)) - 1;
    lo    = -(longint'(1) <<< (W - 1));
    e.ovf = (ex > hi) || (ex < lo);
    raw   = ex;
    e.res = raw[W-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (e.ovf) begin
      raw   = (ex > hi) ? hi : lo;
      e.res = raw[W-1:0];
    end
`endif
    return e;
  endfunction

  // out_ready pattern generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       begin or_tog = ~or_tog; out_ready = or_tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake rule, stall stability, in-order scoreboard.
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_res;
    logic         prev_ovf;
    exp_t         e;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'(1));
          check("hold_result", 64'(result), 64'(prev_res));
          check("hold_overflow", 64'(overflow), 64'(prev_ovf));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got result 0x%0h, expected no beat at %0t", result, $time);
          end else begin
            e = exp_q.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("overflow", 64'(overflow), 64'(e.ovf));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = result;
        prev_ovf   = overflow;
      end
    end
  end

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sub      = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    int waits;
    bit done;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      sub      = vs;
      #1;
      if (in_ready) begin
        exp_q.push_back(model(va, vb, vs));
        done = 1'b1;
      end else if (++waits > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for 1000 cycles, expected acceptance");
        done = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    do begin
      bubble();
      #3;
      cyc++;
    end while (exp_q.size() != 0 && cyc < 500);
    bubble();
  endtask

  task automatic latency_check(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    int cyc;
    drain();
    send(va, vb, vs);
    cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      cyc++;
    end while (!out_valid && cyc < 100);
    check("latency", 64'(cyc), 64'(STAGES));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases, each with a latency measurement.
    or_mode = 0;
    latency_check(W'(16'h1234), W'(16'h0FED), 1'b0);
    latency_check(W'(16'h7FFF), W'(16'h0001), 1'b0);
    latency_check(W'(16'h0000), W'(16'h8000), 1'b1);
    latency_check(W'(16'h0005), W'(16'h0007), 1'b1);
    drain();

    // Back-to-back stream with out_ready toggling 1010...
    or_mode = 1;
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    // Random stream with random bubbles and random backpressure.
    or_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) bubble();
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    or_mode = 0;
    drain();

    // Reset with three beats in flight: they must vanish.
    for (int i = 0; i < 3; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    exp_q.delete();
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_result", 64'(result), 64'(0));
    check("midreset_overflow", 64'(overflow), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Pipeline must be usable again, with no stale beats in front.
    for (int i = 0; i < 10; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (STAGES + 2) bubble();
    check("leftover_beats", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
